// File: rtl/fetch_buf_if.sv
// Fetch-side and instruction-memory-side signals of the fetch buffer.
// The buffer itself connects through the slave modport; its environment uses master.
interface fetch_buf_if;
  logic        branch_request_i;
  logic [31:0] branch_pc_i;
  logic        fetch_accept_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_fault_o;
  logic        mem_i_rd_o;
  logic [31:0] mem_i_pc_o;
  logic        mem_i_flush_o;
  logic        mem_i_invalidate_o;
  logic        mem_i_accept_i;
  logic        mem_i_valid_i;
  logic        mem_i_error_i;
  logic [63:0] mem_i_inst_i;

  modport slave (
    input  branch_request_i, branch_pc_i, fetch_accept_i,
    input  mem_i_accept_i, mem_i_valid_i, mem_i_error_i, mem_i_inst_i,
    output fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_fault_o,
    output mem_i_rd_o, mem_i_pc_o, mem_i_flush_o, mem_i_invalidate_o
  );

  modport master (
    output branch_request_i, branch_pc_i, fetch_accept_i,
    output mem_i_accept_i, mem_i_valid_i, mem_i_error_i, mem_i_inst_i,
    input  fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_fault_o,
    input  mem_i_rd_o, mem_i_pc_o, mem_i_flush_o, mem_i_invalidate_o
  );
endinterface

// File: rtl/fetch_buf.sv
// Instruction fetch buffer: issues 64-bit aligned fetches, queues responses in a small FIFO
// and presents one 32-bit instruction per cycle, with redirect and stale-response discard.
module fetch_buf #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2
) (
  input logic        clk_i,
  input logic        rstn_i,
  fetch_buf_if.slave bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  logic [31:3] pc_q, pc_d;
  logic [31:3] rsp_pc_q, rsp_pc_d;
  cnt_t        count_q, count_d;
  cnt_t        outst_q, outst_d;
  cnt_t        discard_q, discard_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  logic        skip_pend_q, skip_pend_d;

  logic [31:3] addr_mem [DEPTH];
  logic [63:0] inst_mem [DEPTH];
  logic        err_mem  [DEPTH];
  logic        hi_mem   [DEPTH];

  logic        branch;
  logic [CW:0] occ_sum;
  logic        mem_rd;
  logic        req_fire;
  logic        rsp;
  logic        push;
  logic        fetch_vld;
  logic        head_hi;
  logic        take;
  logic        pop;
  logic        set_hi;
  logic [1:0]  unused_pc_lsb;

  assign unused_pc_lsb = bus.branch_pc_i[1:0];

  always_comb begin
    branch    = bus.branch_request_i;
    occ_sum   = {1'b0, outst_q} + {1'b0, count_q};
    // Gated by reset so no request escapes while the block is held in reset.
    mem_rd    = rstn_i & ~branch & (occ_sum < DEPTH_W);
    req_fire  = mem_rd & bus.mem_i_accept_i;
    rsp       = bus.mem_i_valid_i & (outst_q != '0);
    push      = rsp & (discard_q == '0) & ~branch;
    fetch_vld = (count_q != '0) & ~branch;
    head_hi   = hi_mem[rd_ptr_q];
    take      = fetch_vld & bus.fetch_accept_i;
    pop       = take & head_hi;
    set_hi    = take & ~head_hi;
  end

  always_comb begin
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    skip_pend_d = skip_pend_q;
    discard_d   = discard_q;
    outst_d     = outst_q + cnt_t'(req_fire) - cnt_t'(rsp);

    if (branch) begin
      pc_d        = bus.branch_pc_i[31:3];
      rsp_pc_d    = bus.branch_pc_i[31:3];
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      skip_pend_d = bus.branch_pc_i[2];
      // Everything still in flight after this cycle belongs to the old path.
      discard_d   = outst_d;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 29'd1;
      end
      if (rsp && (discard_q != '0)) begin
        discard_d = discard_q - cnt_t'(1);
      end
      if (push) begin
        rsp_pc_d    = rsp_pc_q + 29'd1;
        skip_pend_d = 1'b0;
      end
      count_d  = count_q + cnt_t'(push) - cnt_t'(pop);
      wr_ptr_d = wr_ptr_q + ptr_t'(push);
      rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q        <= BOOT_ADDR[31:3];
      rsp_pc_q    <= BOOT_ADDR[31:3];
      count_q     <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      skip_pend_q <= BOOT_ADDR[2];
    end else begin
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      skip_pend_q <= skip_pend_d;
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (set_hi) begin
      hi_mem[rd_ptr_q] <= 1'b1;
    end
    if (push) begin
      addr_mem[wr_ptr_q] <= rsp_pc_q;
      inst_mem[wr_ptr_q] <= bus.mem_i_inst_i;
      err_mem[wr_ptr_q]  <= bus.mem_i_error_i;
      hi_mem[wr_ptr_q]   <= skip_pend_q;
    end
  end

  always_comb begin
    bus.fetch_valid_o      = fetch_vld;
    bus.fetch_instr_o      = '0;
    bus.fetch_pc_o         = '0;
    bus.fetch_fault_o      = 1'b0;
    if (fetch_vld) begin
      bus.fetch_instr_o = head_hi ? inst_mem[rd_ptr_q][63:32] : inst_mem[rd_ptr_q][31:0];
      bus.fetch_pc_o    = {addr_mem[rd_ptr_q], head_hi, 2'b00};
      bus.fetch_fault_o = err_mem[rd_ptr_q];
    end
    bus.mem_i_rd_o         = mem_rd;
    bus.mem_i_pc_o         = {pc_q, 3'b000};
    bus.mem_i_flush_o      = 1'b0;
    bus.mem_i_invalidate_o = 1'b0;
  end

endmodule
